// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand selection and hazard handling.
// Build macro ID_EX_FORWARD_EN enables EX/MEM and MEM/WB forwarding (load-use stall only).
module id_ex_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter logic [3:0]  NOP_OP     = 4'd5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [3:0]            id_alu_op,
  input  logic                  id_use_imm,
  input  logic                  id_use_pc,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic                  exm_reg_write,
  input  logic [XLEN-1:0]       exm_result,
  input  logic [REG_ADDR_W-1:0] mwb_rd,
  input  logic                  mwb_reg_write,
  input  logic [XLEN-1:0]       mwb_result,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  id_hold,
  output logic [XLEN-1:0]       A,
  output logic [XLEN-1:0]       B,
  output logic [3:0]            S,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_store_data
);

  logic                  valid_q, reg_write_q, mem_read_q, mem_write_q;
  logic                  use_imm_q, use_pc_q;
  logic [REG_ADDR_W-1:0] rd_q, rs1_q, rs2_q;
  logic [XLEN-1:0]       pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [3:0]            op_q;
  logic [XLEN-1:0]       fwd_rs1, fwd_rs2;
  logic                  hazard;
  logic                  bubble;

`ifdef ID_EX_FORWARD_EN
  // Only a load in EX cannot be forwarded in time; stall on either source conservatively.
  assign hazard = valid_q & mem_read_q & (rd_q != '0) & id_valid &
                  ((rd_q == id_rs1) | (rd_q == id_rs2));

  always_comb begin
    fwd_rs1 = rs1_data_q;
    if ((rs1_q != '0) && exm_reg_write && (exm_rd == rs1_q)) begin
      fwd_rs1 = exm_result;
    end else if ((rs1_q != '0) && mwb_reg_write && (mwb_rd == rs1_q)) begin
      fwd_rs1 = mwb_result;
    end
  end

  always_comb begin
    fwd_rs2 = rs2_data_q;
    if ((rs2_q != '0) && exm_reg_write && (exm_rd == rs2_q)) begin
      fwd_rs2 = exm_result;
    end else if ((rs2_q != '0) && mwb_reg_write && (mwb_rd == rs2_q)) begin
      fwd_rs2 = mwb_result;
    end
  end
`else
  logic dep_rs1, dep_rs2;
  logic unused_fwd;

  // Without forwarding, any in-flight writer of a source must retire first.
  assign dep_rs1 = (id_rs1 != '0) &
                   ((valid_q & reg_write_q & (rd_q == id_rs1)) |
                    (exm_reg_write & (exm_rd == id_rs1)) |
                    (mwb_reg_write & (mwb_rd == id_rs1)));
  assign dep_rs2 = (id_rs2 != '0) &
                   ((valid_q & reg_write_q & (rd_q == id_rs2)) |
                    (exm_reg_write & (exm_rd == id_rs2)) |
                    (mwb_reg_write & (mwb_rd == id_rs2)));
  assign hazard  = id_valid & (dep_rs1 | dep_rs2);
  assign fwd_rs1 = rs1_data_q;
  assign fwd_rs2 = rs2_data_q;
  assign unused_fwd = ^{exm_result, mwb_result, rs1_q, rs2_q};
`endif

  assign bubble = flush | (~stall & hazard);

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      use_imm_q   <= 1'b0;
      use_pc_q    <= 1'b0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      op_q        <= NOP_OP;
    end else if (!stall) begin
      valid_q     <= id_valid;
      reg_write_q <= id_reg_write;
      mem_read_q  <= id_mem_read;
      mem_write_q <= id_mem_write;
      use_imm_q   <= id_use_imm;
      use_pc_q    <= id_use_pc;
      rd_q        <= id_rd;
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      pc_q        <= id_pc;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      imm_q       <= id_imm;
      op_q        <= id_alu_op;
    end
  end

  assign id_hold       = stall | hazard;
  assign A             = use_pc_q ? pc_q : fwd_rs1;
  assign B             = use_imm_q ? imm_q : fwd_rs2;
  assign S             = op_q;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_rd         = rd_q;
  assign ex_pc         = pc_q;
  assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus reset, flush/stall, hazard and forward sequences.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_use_imm, id_use_pc, id_reg_write, id_mem_read, id_mem_write;
  logic [4:0]  exm_rd, mwb_rd;
  logic        exm_reg_write, mwb_reg_write;
  logic [31:0] exm_result, mwb_result;
  logic        stall, flush;
  logic        id_hold;
  logic [31:0] A, B, ex_pc, ex_store_data;
  logic [3:0]  S;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd;

  int total = 0;
  int bad   = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_use_imm(id_use_imm), .id_use_pc(id_use_pc),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
    .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result),
    .stall(stall), .flush(flush), .id_hold(id_hold), .A(A), .B(B), .S(S),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_pc(ex_pc),
    .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
    logic [3:0]  op;
    logic        ui, up, rw, mw;
    logic [31:0] ea, eb;
    logic [3:0]  es;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] op,
                        input logic ui, input logic up, input logic rw, input logic mr,
                        input logic mw);
    id_valid = v;  id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_pc = pc; id_alu_op = op;
    id_use_imm = ui; id_use_pc = up; id_reg_write = rw; id_mem_read = mr;
    id_mem_write = mw;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{5'd1, 5'd2, 5'd3, 32'd10, 32'd20, 32'd0, 32'h100, 4'd5,
                1'b0, 1'b0, 1'b1, 1'b0, 32'd10, 32'd20, 4'd5};
    vecs[1] = '{5'd4, 5'd5, 5'd6, 32'hdead, 32'd7, 32'hfffffff0, 32'h104, 4'd0,
                1'b1, 1'b0, 1'b1, 1'b1, 32'hdead, 32'hfffffff0, 4'd0};
    vecs[2] = '{5'd1, 5'd2, 5'd0, 32'd3, 32'd4, 32'd8, 32'h108, 4'd2,
                1'b1, 1'b1, 1'b0, 1'b0, 32'h108, 32'd8, 4'd2};
    vecs[3] = '{5'd7, 5'd8, 5'd31, 32'h55, 32'haa, 32'd1, 32'h10c, 4'd9,
                1'b0, 1'b0, 1'b1, 1'b0, 32'h55, 32'haa, 4'd9};

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    exm_rd = '0; exm_reg_write = 1'b0; exm_result = '0;
    mwb_rd = '0; mwb_reg_write = 1'b0; mwb_result = '0;
    set_id(1'b1, 5'd1, 5'd2, 5'd4, 32'd10, 32'd20, 32'd3, 32'h40, 4'd3,
           1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (2) tick();
    chk("rst ex_valid", 32'(ex_valid), 32'd0);
    chk("rst S", 32'(S), 32'd5);
    chk("rst A", A, 32'd0);
    chk("rst B", B, 32'd0);
    chk("rst store", ex_store_data, 32'd0);
    chk("rst ex_rd", 32'(ex_rd), 32'd0);
    chk("rst ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write}), 32'd0);
    chk("rst id_hold", 32'(id_hold), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      set_id(1'b1, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].d1, vecs[i].d2,
             vecs[i].imm, vecs[i].pc, vecs[i].op, vecs[i].ui, vecs[i].up, vecs[i].rw,
             1'b0, vecs[i].mw);
      tick();
      chk($sformatf("vec%0d A", i), A, vecs[i].ea);
      chk($sformatf("vec%0d B", i), B, vecs[i].eb);
      chk($sformatf("vec%0d S", i), 32'(S), 32'(vecs[i].es));
      chk($sformatf("vec%0d ex_valid", i), 32'(ex_valid), 32'd1);
      chk($sformatf("vec%0d ex_rd", i), 32'(ex_rd), 32'(vecs[i].rd));
      chk($sformatf("vec%0d ex_pc", i), ex_pc, vecs[i].pc);
      chk($sformatf("vec%0d store", i), ex_store_data, vecs[i].d2);
      chk($sformatf("vec%0d ctrl", i), 32'({ex_reg_write, ex_mem_write}),
          32'({vecs[i].rw, vecs[i].mw}));
      chk($sformatf("vec%0d id_hold", i), 32'(id_hold), 32'd0);
    end

    // Flush wins over stall.
    set_id(1'b1, 5'd1, 5'd2, 5'd12, 32'h11, 32'h22, 32'd0, 32'h200, 4'd1,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("pre-flush A", A, 32'h11);
    stall = 1'b1; flush = 1'b1;
    tick();
    chk("flush ex_valid", 32'(ex_valid), 32'd0);
    chk("flush S", 32'(S), 32'd5);
    chk("flush A", A, 32'd0);
    chk("flush ex_rd", 32'(ex_rd), 32'd0);
    stall = 1'b0; flush = 1'b0;
    set_id(1'b1, 5'd1, 5'd2, 5'd13, 32'h31, 32'h32, 32'd0, 32'h204, 4'd7,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    stall = 1'b1;
    set_id(1'b1, 5'd3, 5'd4, 5'd14, 32'h99, 32'h98, 32'd0, 32'h208, 4'd2,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("stall%0d A", c), A, 32'h31);
      chk($sformatf("stall%0d B", c), B, 32'h32);
      chk($sformatf("stall%0d S", c), 32'(S), 32'd7);
      chk($sformatf("stall%0d ex_rd", c), 32'(ex_rd), 32'd13);
      chk($sformatf("stall%0d id_hold", c), 32'(id_hold), 32'd1);
    end
    stall = 1'b0;
    tick();
    chk("unstall A", A, 32'h99);
    chk("unstall B", B, 32'h98);

    // Load-use on rs2: one bubble, then issue.
    set_id(1'b1, 5'd1, 5'd0, 5'd5, 32'h1000, 32'd0, 32'd4, 32'h300, 4'd5,
           1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("lw mem_read", 32'(ex_mem_read), 32'd1);
    chk("lw A", A, 32'h1000);
    chk("lw B", B, 32'd4);
    set_id(1'b1, 5'd4, 5'd5, 5'd6, 32'h40, 32'h50, 32'd0, 32'h304, 4'd0,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu id_hold", 32'(id_hold), 32'd1);
    tick();
    chk("lu bubble valid", 32'(ex_valid), 32'd0);
    chk("lu bubble S", 32'(S), 32'd5);
    chk("lu release hold", 32'(id_hold), 32'd0);
    tick();
    chk("lu issue valid", 32'(ex_valid), 32'd1);
    chk("lu issue A", A, 32'h40);
    chk("lu issue B", B, 32'h50);
    chk("lu issue rd", 32'(ex_rd), 32'd6);

    // Reset in the middle of a hazard clears the hold.
    set_id(1'b1, 5'd1, 5'd0, 5'd5, 32'h1000, 32'd0, 32'd4, 32'h308, 4'd5,
           1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd4, 5'd5, 5'd6, 32'h40, 32'h50, 32'd0, 32'h30c, 4'd0,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("rh id_hold", 32'(id_hold), 32'd1);
    rst = 1'b1;
    tick();
    chk("rh ex_valid", 32'(ex_valid), 32'd0);
    chk("rh id_hold", 32'(id_hold), 32'd0);
    chk("rh S", 32'(S), 32'd5);
    rst = 1'b0;

`ifdef ID_EX_FORWARD_EN
    set_id(1'b1, 5'd3, 5'd0, 5'd0, 32'h333, 32'd0, 32'd0, 32'h400, 4'd5,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    stall = 1'b1;
    exm_rd = 5'd3; exm_reg_write = 1'b1; exm_result = 32'h111;
    mwb_rd = 5'd3; mwb_reg_write = 1'b1; mwb_result = 32'h222;
    #1;
    chk("fwd exm wins", A, 32'h111);
    exm_reg_write = 1'b0;
    #1;
    chk("fwd mwb", A, 32'h222);
    stall = 1'b0; mwb_reg_write = 1'b0;
    exm_rd = 5'd0; exm_reg_write = 1'b1;
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 32'h444, 32'h555, 32'd0, 32'h404, 4'd5,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fwd x0 A", A, 32'h444);
    chk("fwd x0 store", ex_store_data, 32'h555);
    exm_reg_write = 1'b0;
`else
    exm_rd = 5'd7; exm_reg_write = 1'b1; exm_result = 32'h999;
    set_id(1'b1, 5'd7, 5'd1, 5'd8, 32'h77, 32'h11, 32'd0, 32'h400, 4'd5,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("raw exm hold", 32'(id_hold), 32'd1);
    tick();
    chk("raw exm bubble", 32'(ex_valid), 32'd0);
    chk("raw exm S", 32'(S), 32'd5);
    exm_reg_write = 1'b0;
    mwb_rd = 5'd7; mwb_reg_write = 1'b1; mwb_result = 32'h888;
    #1;
    chk("raw mwb hold", 32'(id_hold), 32'd1);
    tick();
    chk("raw mwb bubble", 32'(ex_valid), 32'd0);
    mwb_reg_write = 1'b0;
    #1;
    chk("raw clear hold", 32'(id_hold), 32'd0);
    tick();
    chk("raw issue valid", 32'(ex_valid), 32'd1);
    chk("raw issue A", A, 32'h77);
    chk("raw issue B", B, 32'h11);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-side operand selection. Drives the ALU operand/opcode inputs A, B, S.
- Registers decoded fields each cycle and applies EX/MEM and MEM/WB forwarding to the registered source values.
- Detects load-use hazards, inserts a bubble and holds the decode stage.
- Owns flush (branch/jump redirect) and external stall behaviour for the EX stage.

Parameters:
- XLEN, 32, datapath width; A/B are XLEN bits.
- REG_ADDR_W, 5, register index width.
- NOP_OP, 4'd5, ALU opcode driven during reset/bubble (ALU_ADD).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W each  source/destination indices
- id_rs1_data, id_rs2_data  in  XLEN each  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_alu_op  in  4  AluOp encoding
- id_use_imm  in  1  B := imm instead of rs2
- id_use_pc  in  1  A := pc instead of rs1
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
- exm_rd  in  REG_ADDR_W; exm_reg_write  in  1; exm_result  in  XLEN  EX/MEM forward source
- mwb_rd  in  REG_ADDR_W; mwb_reg_write  in  1; mwb_result  in  XLEN  MEM/WB forward source
- stall  in  1  external hold (e.g. memory busy)
- flush  in  1  kill the instruction entering EX
- id_hold  out  1  decode must not advance this cycle
- A, B  out  XLEN  ALU operands
- S  out  4  ALU opcode
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1 each
- ex_rd  out  REG_ADDR_W; ex_pc  out  XLEN; ex_store_data  out  XLEN  forwarded rs2 value

Behaviour:
- Update priority per rising edge: rst > flush > stall > load_use > load.
- rst: all registers cleared. ex_valid=0, control bits 0, ex_rd=0, S=NOP_OP, registered data 0. A=B=0, ex_store_data=0.
- flush: load a bubble regardless of stall or load_use.
  - Bubble = valid 0, all control bits 0, rd 0, op NOP_OP, data 0.
- stall (no flush): all EX registers hold.
- load_use (no flush/stall): load a bubble; decode holds via id_hold.
  - load_use = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - Conservative: both sources are checked regardless of id_use_imm.
- load: capture all id_* fields; ex_valid=id_valid.
- id_hold = stall | load_use, combinational.
- Forwarding is combinational from the registered rs1/rs2 indices/data, per source:
  - if index!=0 & exm_reg_write & exm_rd==index: use exm_result
  - else if index!=0 & mwb_reg_write & mwb_rd==index: use mwb_result
  - else: use the registered data
  - EX/MEM wins when both match. x0 is never forwarded.
- A = use_pc ? pc : fwd_rs1.
- B = use_imm ? imm : fwd_rs2.
- ex_store_data = fwd_rs2, always.
- S = registered op.
- Latency: decode values appear on A/B/S one cycle after capture. Forwarded values are zero-cycle from the forward ports.
- Reset mid-stall or mid-hazard: the next cycle shows reset values and id_hold=0 (ex_valid=0 kills load_use).

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: forwarding as above; only load-use stalls.
- Undefined:
  - Forward muxes are removed; A/B use registered data only.
  - raw_hazard replaces load_use in the priority list and in id_hold.
  - raw_hazard = id_valid & any nonzero id_rs1/id_rs2 matching any of:
    - ex_rd with ex_valid & ex_reg_write
    - exm_rd with exm_reg_write
    - mwb_rd with mwb_reg_write
  - On raw_hazard: bubble is inserted and decode is held until clear.

Test Plan:
- Reset: assert rst two cycles with id fields nonzero -> ex_valid=0, S=5, A=B=0, id_hold=0.
- ADD capture: id rs1=1 data 10, rs2=2 data 20, op=5, use_imm=0 -> next cycle A=10, B=20, S=5, ex_valid=1.
- Forward priority: EX holds rs1=3; exm_rd=3 result 0x111 and mwb_rd=3 result 0x222, both write -> A=0x111. Drop exm_reg_write -> A=0x222. Set rs1=0 -> A=registered data.
- Load-use: EX has lw rd=5; decode instr rs2=5 -> id_hold=1 one cycle. Next cycle ex_valid=0, S=5; the following cycle the instr enters with ex_valid=1.
- Flush vs stall: stall=1 and flush=1 together -> bubble loaded. stall=1 alone for 3 cycles -> A/B/S/ex_rd unchanged, id_hold=1.
- Without ID_EX_FORWARD_EN: exm_rd=7 write; decode rs1=7 -> id_hold=1 and bubbles until exm/mwb/ex no longer match, then the instruction issues with register data.
